load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the CPU datapath and `DataMemory`. It turns CPU load/store requests (byte, halfword or word; signed or unsigned loads) into word-wide accesses on `DataMemory`'s byte-addressed port. Sub-word stores run as a two-step read-modify-write sequenced by a small FSM. Loads are returned as a registered, extended result with a one-cycle valid pulse.

## Interface
- `WIDTH`, 32, data word width; must equal 8*`BPW`
- `BPW`, 4, bytes per word
- `DEPTH`, 50, words in `DataMemory`
- `AW`, $clog2(`DEPTH`*`BPW`), byte-address width
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present; sampled only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_signed`  in  1  sign-extend load result
- `req_addr`  in  AW  byte address
- `req_wdata`  in  WIDTH  store data, right-aligned for sub-word sizes
- `busy`  out  1  high while state != IDLE (combinational from state)
- `done`  out  1  one-cycle pulse when a legal request completes
- `rdata_valid`  out  1  one-cycle pulse; `rdata` holds a load result
- `rdata`  out  WIDTH  registered load result
- `misaligned_err`  out  1  one-cycle pulse for an illegal or misaligned request
- `mem_read_address`, `mem_write_address`  out  AW  word-aligned byte address (low log2(BPW) bits = 0)
- `mem_write_data`  out  WIDTH  full word to write
- `mem_write_en`, `mem_read_en`  out  1  memory strobes
- `mem_read_data`  in  WIDTH  combinational read data from `DataMemory`

## Operation
- Memory model:
  - Read is combinational while `mem_read_en` = 1.
  - Write commits at the rising edge when `mem_write_en` = 1.
- Byte lanes are little-endian:
  - Byte offset k maps to bits [8k+7:8k].
  - A half at offset 2h maps to [16h+15:16h].
- Alignment check, done in IDLE when `req_valid` = 1:
  - Half requires addr[0] = 0.
  - Word requires addr[log2(BPW)-1:0] = 0.
  - Size 11 is illegal.
  - On failure: `misaligned_err` pulses next cycle, no memory strobe is issued, state stays IDLE, and `done` is not asserted.
- FSM states are IDLE, RD, WR.
  - IDLE + legal load -> RD.
  - IDLE + legal word store -> WR.
  - IDLE + legal sub-word store -> RD.
  - RD (load): `mem_read_en` = 1. The selected lane is zero- or sign-extended into `rdata`. `done` and `rdata_valid` are set. Next state is IDLE.
  - RD (sub-word store): `mem_read_en` = 1. `mem_read_data` is merged with the low byte/half of `req_wdata` into the write register (other lanes preserved). Next state is WR.
  - WR: `mem_write_en` = 1, `mem_write_data` = write register (word store = `req_wdata`). `done` is set. Next state is IDLE.
- The request is captured into internal registers on acceptance. The CPU may change inputs afterwards.
- `req_valid` is ignored while `busy`.
- `rdata` holds its value until the next completed load.

## Timing
- Request accepted at edge E0 (IDLE, `req_valid` = 1).
- Load: RD during E0–E1. `rdata_valid`/`done` are high during E1–E2. A new request may be accepted at E2.
- Word store: WR during E0–E1, memory updated at E1. `done` is high during E1–E2.
- Sub-word store: RD during E0–E1, WR during E1–E2, memory updated at E2. `done` is high during E2–E3.
- Misaligned request: `misaligned_err` is high during E0–E1.
- A load issued right after a store's `done` sees the stored data (no forwarding needed).
- Reset values of all outputs are 0, state is IDLE, and internal registers are 0.
- Reset in RD or WR:
  - State goes to IDLE at that edge and the pending write is dropped.
  - `mem_write_en` is 0 from the next cycle onward.
  - No `done` or `rdata_valid` pulse is produced for the aborted request.

## Test plan
- Word store 0xFAB01234 to 0x04, then word load 0x04 -> `done` 1 cycle after accept; `rdata` = 0xFAB01234, `rdata_valid` 2 cycles after the load request.
- Byte store 0xAB to 0x05 (memory word 0xFAB01234) -> RD then WR, memory word = 0xFAB0AB34. Signed byte load 0x05 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half loads at 0x06: signed -> 0xFFFFFAB0, unsigned -> 0x0000FAB0. Half store 0x5555 to 0x06 -> memory word = 0x5555AB34.
- Half request at 0x03, word request at 0x02, and `req_size` = 11 -> `misaligned_err` pulse each, no `mem_*_en`, no `done`, memory unchanged.
- Word store 0xDEADBEEF to 0xC4 (last word), read back -> `rdata` = 0xDEADBEEF. `req_valid` pulsed while `busy` -> ignored.
- Byte store in flight, `reset` asserted during RD -> no `mem_write_en`, memory unchanged, all outputs 0 after the edge, next request processed normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word-wide DataMemory
// accesses; sub-word stores are read-modify-write through RD then WR.
module lsu_lane (
    input  logic       sel,
    input  logic [7:0] rd_byte,
    input  logic [7:0] wr_byte,
    output logic [7:0] merged
);
    assign merged = sel ? wr_byte : rd_byte;
endmodule

module load_store_unit #(
    parameter int WIDTH = 32,
    parameter int BPW   = 4,
    parameter int DEPTH = 50,
    parameter int AW    = $clog2(DEPTH*BPW)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             busy,
    output logic             done,
    output logic             rdata_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             misaligned_err,
    output logic [AW-1:0]    mem_read_address,
    output logic [AW-1:0]    mem_write_address,
    output logic [WIDTH-1:0] mem_write_data,
    output logic             mem_write_en,
    output logic             mem_read_en,
    input  logic [WIDTH-1:0] mem_read_data
);
    localparam int AO = $clog2(BPW);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]    addr_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic             write_q;
    logic [WIDTH-1:0] wbuf;
    logic             legal;
    logic [AO-1:0]    off;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_ext;
    logic [BPW-1:0][7:0] rd_lanes;
    logic [BPW-1:0][7:0] mg_lanes;

    always_comb begin
        legal = 1'b0;
        case (req_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~req_addr[0];
            2'b10:   legal = (req_addr[AO-1:0] == '0);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid && legal)
                      state_nxt = (req_write && req_size == 2'b10) ? WR : RD;
            RD:   state_nxt = write_q ? WR : IDLE;
            WR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign off      = addr_q[AO-1:0];
    assign rd_lanes = mem_read_data;

    // Lane merge for sub-word stores: selected lanes take the store data, the rest keep memory.
    for (genvar k = 0; k < BPW; k++) begin : g_lane
        localparam int HK = k / 2;
        logic       sel;
        logic [7:0] wr_byte;
        always_comb begin
            if (size_q == 2'b00) begin
                sel     = (off == AO'(k));
                wr_byte = wbuf[7:0];
            end else begin
                sel     = (off[AO-1:1] == (AO-1)'(HK));
                wr_byte = wbuf[8*(k%2) +: 8];
            end
        end
        lsu_lane u_lane (
            .sel     (sel),
            .rd_byte (rd_lanes[k]),
            .wr_byte (wr_byte),
            .merged  (mg_lanes[k])
        );
    end

    assign shifted = mem_read_data >> {off, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{(WIDTH-8){signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{(WIDTH-16){signed_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q         <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            write_q        <= 1'b0;
            wbuf           <= '0;
            rdata          <= '0;
            done           <= 1'b0;
            rdata_valid    <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            done           <= 1'b0;
            rdata_valid    <= 1'b0;
            misaligned_err <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    if (legal) begin
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        wbuf     <= req_wdata;
                    end else begin
                        misaligned_err <= 1'b1;
                    end
                end
                RD: begin
                    if (write_q) begin
                        wbuf <= mg_lanes;
                    end else begin
                        rdata       <= load_ext;
                        done        <= 1'b1;
                        rdata_valid <= 1'b1;
                    end
                end
                WR: done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy              = (state != IDLE);
    assign mem_read_en       = (state == RD);
    assign mem_write_en      = (state == WR);
    assign mem_read_address  = {addr_q[AW-1:AO], {AO{1'b0}}};
    assign mem_write_address = {addr_q[AW-1:AO], {AO{1'b0}}};
    assign mem_write_data    = wbuf;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: DataMemory model, byte-array reference model,
// directed table, reset/busy sequences and randomized requests.
module tb_load_store_unit;
    localparam int WIDTH = 32;
    localparam int BPW   = 4;
    localparam int DEPTH = 50;
    localparam int AW    = $clog2(DEPTH*BPW);

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_write, req_signed;
    logic [1:0]       req_size;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             busy, done, rdata_valid, misaligned_err;
    logic [WIDTH-1:0] rdata;
    logic [AW-1:0]    mem_read_address, mem_write_address;
    logic [WIDTH-1:0] mem_write_data, mem_read_data;
    logic             mem_write_en, mem_read_en;

    load_store_unit #(.WIDTH(WIDTH), .BPW(BPW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata_valid(rdata_valid), .rdata(rdata),
        .misaligned_err(misaligned_err),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // DataMemory model
    logic [31:0] dmem [0:DEPTH-1];
    logic        mem_clr;
    int          ridx, widx;
    assign ridx = int'(mem_read_address) / 4;
    assign widx = int'(mem_write_address) / 4;
    assign mem_read_data = (mem_read_en && ridx < DEPTH) ? dmem[ridx] : 32'h0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= 32'h0;
        end else if (mem_write_en && widx < DEPTH) begin
            dmem[widx] <= mem_write_data;
        end
    end

    // Reference model: flat byte array
    logic [7:0]  ref_b [0:DEPTH*BPW-1];
    logic [31:0] last_rd;
    int n_cmp = 0, n_bad = 0;

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int sz, input logic sg);
        int n = 1 << sz;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[a+i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic ref_store(input int a, input int sz, input logic [31:0] d);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) ref_b[a+i] = d[8*i +: 8];
    endtask

    function automatic logic ref_legal(input int a, input int sz);
        if (sz == 3) return 1'b0;
        return (a % (1 << sz)) == 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One request, observed for five cycles after acceptance.
    task automatic check_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [7:0] a, input logic [31:0] d,
                             input logic exp_err, input logic [31:0] exp_val,
                             input logic poke);
        int done_k = 0, err_k = 0, rv_k = 0, done_n = 0, err_n = 0;
        int strobes = 0, bad_al = 0, exp_k;
        logic busy1;
        logic [31:0] got_rd = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = 8'($urandom); req_wdata = $urandom; req_signed = 1'($urandom);
        busy1 = busy;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (poke) begin
                if (k == 1) begin
                    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
                    req_addr = 8'h08; req_wdata = 32'h12345678;
                end else req_valid = 1'b0;
            end
            if (done) begin done_n++; if (done_k == 0) done_k = k; end
            if (misaligned_err) begin err_n++; if (err_k == 0) err_k = k; end
            if (rdata_valid && rv_k == 0) begin rv_k = k; got_rd = rdata; end
            if (mem_read_en || mem_write_en) begin
                strobes++;
                if (mem_read_address[1:0] != 2'b00 || mem_write_address[1:0] != 2'b00) bad_al++;
            end
        end
        exp_k = exp_err ? 0 : ((!w || sz == 2'b10) ? 2 : 3);
        chk("busy_after_accept", 32'(busy1), 32'(!exp_err));
        chk("done_cycle", done_k, exp_k);
        chk("done_count", done_n, exp_err ? 0 : 1);
        chk("err_cycle", err_k, exp_err ? 1 : 0);
        chk("err_count", err_n, exp_err ? 1 : 0);
        chk("rvalid_cycle", rv_k, (!exp_err && !w) ? 2 : 0);
        chk("addr_aligned", bad_al, 0);
        if (exp_err) chk("err_no_strobe", strobes, 0);
        if (!exp_err && !w) begin
            chk("rdata", got_rd, exp_val);
            last_rd = exp_val;
        end else begin
            chk("mem_word", dmem[a >> 2], exp_val);
        end
        chk("rdata_hold", rdata, last_rd);
        if (poke) chk("busy_req_ignored", dmem[2], ref_word(2));
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [7:0]  a;
        logic [31:0] d;
        logic        err;
        logic [31:0] exp;
        logic        poke;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int wt, zt, dt;
        logic [31:0] ev;
        logic        w, sg, legal, poke;
        logic [1:0]  sz;
        logic [7:0]  a;
        logic [31:0] d;
        int          r;

        for (int i = 0; i < DEPTH*BPW; i++) ref_b[i] = 8'h0;
        last_rd = 32'h0;
        reset = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; mem_clr = 1'b0;

        chk("rst_flags", {26'h0, busy, done, rdata_valid, misaligned_err, mem_write_en, mem_read_en}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_addr", {16'h0, mem_read_address, mem_write_address}, 32'h0);

        //           w     sz     sg    a      d              err   exp           poke
        tbl.push_back('{1'b1, 2'd2, 1'b0, 8'h04, 32'hFAB01234, 1'b0, 32'hFAB01234, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 8'h04, 32'h0,        1'b0, 32'hFAB01234, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 8'h05, 32'h123456AB, 1'b0, 32'hFAB0AB34, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 8'h05, 32'h0,        1'b0, 32'hFFFFFFAB, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 8'h05, 32'h0,        1'b0, 32'h000000AB, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 8'h06, 32'h0,        1'b0, 32'hFFFFFAB0, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 8'h06, 32'h0,        1'b0, 32'h0000FAB0, 1'b0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 8'h06, 32'hAAAA5555, 1'b0, 32'h5555AB34, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 8'h04, 32'h0,        1'b0, 32'h5555AB34, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 8'h03, 32'h0,        1'b1, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 8'h02, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 8'h04, 32'hFFFFFFFF, 1'b1, 32'h5555AB34, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 8'hC4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 8'hC4, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 8'hC7, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 8'hC4, 32'h0,        1'b0, 32'h0000BEEF, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 8'hC7, 32'hFFFFFF11, 1'b0, 32'h11ADBEEF, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 8'hC4, 32'h0,        1'b0, 32'h11ADBEEF, 1'b0});

        foreach (tbl[i]) begin
            if (!tbl[i].err && tbl[i].w) ref_store(int'(tbl[i].a), int'(tbl[i].sz), tbl[i].d);
            check_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d,
                      tbl[i].err, tbl[i].exp, tbl[i].poke);
        end

        // Reset while a byte store sits in RD: the write must never reach memory.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'h10; req_wdata = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_flags", {26'h0, busy, done, rdata_valid, misaligned_err, mem_write_en, mem_read_en}, 32'h0);
        chk("rst_mid_rdata", rdata, 32'h0);
        chk("rst_mid_wdata", mem_write_data, 32'h0);
        last_rd = 32'h0;
        wt = 0; zt = 0; dt = 0;
        for (int k = 0; k < 3; k++) begin
            if (mem_write_en) wt++;
            if (done || rdata_valid) dt++;
            if (busy) zt++;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_write", wt, 0);
        chk("rst_mid_no_done", dt, 0);
        chk("rst_mid_idle", zt, 0);
        chk("rst_mid_mem", dmem[4], ref_word(4));
        check_req(1'b0, 2'd0, 1'b0, 8'h10, 32'h0, 1'b0, ref_load(16, 0, 1'b0), 1'b0);
        ref_store(16, 0, 32'h5A);
        check_req(1'b1, 2'd0, 1'b0, 8'h10, 32'h5A, 1'b0, ref_word(4), 1'b0);

        // Randomized requests against the reference model.
        for (int t = 0; t < 200; t++) begin
            w  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            sg = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, DEPTH*BPW-1));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
            d  = $urandom;
            legal = ref_legal(int'(a), int'(sz));
            if (!legal) ev = ref_word(int'(a) / 4);
            else if (!w) ev = ref_load(int'(a), int'(sz), sg);
            else begin
                ref_store(int'(a), int'(sz), d);
                ev = ref_word(int'(a) / 4);
            end
            poke = legal && !w && (a[7:2] != 6'd2) && ($urandom_range(0, 7) == 0);
            check_req(w, sz, sg, a, d, !legal, ev, poke);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
